// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file: x0 hardwired to zero, optional write-through bypass, issue/writeback busy scoreboard.
// Latency: reads are combinational; register data, busy bits and busy_cnt update at the next rising clk edge.
// Backpressure: none; issue and write are accepted every cycle, and consumers decide to stall from rd_busy.
module regfile_mp_sb #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    output logic [AW:0]            busy_cnt,
    output logic                   any_busy
);

    logic [WIDTH-1:0] regMem [NREGS];
    logic [NREGS-1:0] busyBits;
    logic [NREGS-1:0] busyNext;
    logic [AW:0]      busyCnt;
    logic             wrHit;
    logic             issHit;
    logic             cntInc;
    logic             cntDec;

    // Writes and issues that target x0 have no architectural effect.
    assign wrHit  = we && (waddr != '0);
    assign issHit = issue_valid && (issue_rd != '0);

    // Register storage: x0 is cleared on reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regMem[r] <= '0;
            end
        end else if (wrHit) begin
            regMem[waddr] <= wdata;
        end
    end

    // Next busy vector and count deltas; applying the set after the clear makes a new issue win over a completing write.
    always_comb begin
        busyNext = busyBits;
        if (wrHit) begin
            busyNext[waddr] = 1'b0;
        end
        if (issHit) begin
            busyNext[issue_rd] = 1'b1;
        end
        busyNext[0] = 1'b0;
        cntInc = issHit && !busyBits[issue_rd];
        cntDec = wrHit && busyBits[waddr] && !(issHit && (issue_rd == waddr));
    end

    // Busy bits and their running population count move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyBits <= '0;
            busyCnt  <= '0;
        end else begin
            busyBits <= busyNext;
            busyCnt  <= busyCnt + {{AW{1'b0}}, cntInc} - {{AW{1'b0}}, cntDec};
        end
    end

    assign busy_cnt = busyCnt;
    assign any_busy = (busyCnt != '0);

    for (genvar i = 0; i < NREAD; i++) begin : gRead
        logic [AW-1:0]    pAddr;
        logic [WIDTH-1:0] pData;
        logic             pBusy;

        assign pAddr = rd_addr[i*AW +: AW];

        // Per-port read: x0 reads zero and idle; a forwarded write returns wdata and is no longer a hazard.
        always_comb begin
            pData = regMem[pAddr];
            pBusy = busyBits[pAddr];
            if (pAddr == '0) begin
                pData = '0;
                pBusy = 1'b0;
            end else if ((BYPASS != 0) && we && (waddr == pAddr)) begin
                pData = wdata;
                pBusy = 1'b0;
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = pData;
        assign rd_busy[i]                = pBusy;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: one instance with bypass, one without, driven by identical directed vectors.
// Expected outputs for each cycle are queued by the driver and compared by a monitor on the falling edge.
// The stimulus does not wait on the DUT; a watchdog bounds the run.
module tb_regfile_mp_sb;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;

    logic [63:0] rdDataA, rdDataB;
    logic [1:0]  rdBusyA, rdBusyB;
    logic [5:0]  busyCntA, busyCntB;
    logic        anyBusyA, anyBusyB;

    typedef struct {
        string       name;
        logic [31:0] d0a;
        logic [31:0] d1a;
        logic [1:0]  ba;
        logic [5:0]  cnt;
        logic [31:0] d0b;
        logic [1:0]  bb;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    regfile_mp_sb #(.WIDTH(32), .NREGS(32), .AW(5), .NREAD(2), .BYPASS(1)) dutA (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdDataA), .rd_busy(rdBusyA),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_cnt(busyCntA), .any_busy(anyBusyA)
    );

    regfile_mp_sb #(.WIDTH(32), .NREGS(32), .AW(5), .NREAD(2), .BYPASS(0)) dutB (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rdDataB), .rd_busy(rdBusyB),
        .we(we), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy_cnt(busyCntB), .any_busy(anyBusyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, field, act, exp);
        end
    endtask

    // Monitor: every cycle that has a queued expectation is compared on the falling edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk(e.name, "A.rd_data0", rdDataA[31:0], e.d0a);
            chk(e.name, "A.rd_data1", rdDataA[63:32], e.d1a);
            chk(e.name, "A.rd_busy", {30'd0, rdBusyA}, {30'd0, e.ba});
            chk(e.name, "A.busy_cnt", {26'd0, busyCntA}, {26'd0, e.cnt});
            chk(e.name, "A.any_busy", {31'd0, anyBusyA}, {31'd0, (e.cnt != 6'd0)});
            chk(e.name, "B.rd_data0", rdDataB[31:0], e.d0b);
            chk(e.name, "B.rd_busy", {30'd0, rdBusyB}, {30'd0, e.bb});
            chk(e.name, "B.busy_cnt", {26'd0, busyCntB}, {26'd0, e.cnt});
        end
    end

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir, input logic [4:0] a0, input logic [4:0] a1);
        we          = w;
        waddr       = wa;
        wdata       = wd;
        issue_valid = iv;
        issue_rd    = ir;
        rd_addr     = {a1, a0};
    endtask

    task automatic push(input string nm, input logic [31:0] e0a, input logic [31:0] e1a, input logic [1:0] eba,
                        input logic [5:0] ecnt, input logic [31:0] e0b, input logic [1:0] ebb);
        exp_t e;
        e.name = nm; e.d0a = e0a; e.d1a = e1a; e.ba = eba; e.cnt = ecnt; e.d0b = e0b; e.bb = ebb;
        expQ.push_back(e);
    endtask

    // One clock cycle of stimulus with the outputs expected during that cycle (before its closing edge).
    task automatic cyc(input string nm, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ir, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0a, input logic [31:0] e1a, input logic [1:0] eba,
                       input logic [5:0] ecnt, input logic [31:0] e0b, input logic [1:0] ebb);
        @(posedge clk);
        #1;
        drive(w, wa, wd, iv, ir, a0, a1);
        push(nm, e0a, e1a, eba, ecnt, e0b, ebb);
    endtask

    // Register contents established by the directed writes before the fill sequence.
    function automatic logic [31:0] regVal(input logic [4:0] a);
        case (a)
            5'd5:    return 32'h1234_5678;
            5'd7:    return 32'hA5A5_A5A5;
            5'd9:    return 32'h0000_0066;
            5'd10:   return 32'h0000_0010;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        //   name          we   wa     wdata          iv   ir     a0     a1     expA0          expA1          bA     cnt    expB0          bB
        cyc("rst_read",    0, 5'd0,  32'h0,         0, 5'd0,  5'd0,  5'd31, 32'h0,         32'h0,         2'b00, 6'd0,  32'h0,         2'b00);
        cyc("wr_x0",       1, 5'd0,  32'hDEADBEEF,  0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 6'd0,  32'h0,         2'b00);
        cyc("rd_x0",       0, 5'd0,  32'h0,         0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 6'd0,  32'h0,         2'b00);
        cyc("byp5",        1, 5'd5,  32'h12345678,  0, 5'd0,  5'd5,  5'd5,  32'h12345678,  32'h12345678,  2'b00, 6'd0,  32'h0,         2'b00);
        cyc("rd5_next",    0, 5'd0,  32'h0,         0, 5'd0,  5'd5,  5'd0,  32'h12345678,  32'h0,         2'b00, 6'd0,  32'h12345678,  2'b00);
        cyc("iss7",        0, 5'd0,  32'h0,         1, 5'd7,  5'd7,  5'd5,  32'h0,         32'h12345678,  2'b00, 6'd0,  32'h0,         2'b00);
        cyc("busy7",       0, 5'd0,  32'h0,         0, 5'd0,  5'd7,  5'd7,  32'h0,         32'h0,         2'b11, 6'd1,  32'h0,         2'b11);
        cyc("wr7",         1, 5'd7,  32'hA5A5A5A5,  0, 5'd0,  5'd7,  5'd3,  32'hA5A5A5A5,  32'h0,         2'b00, 6'd1,  32'h0,         2'b01);
        cyc("after_wr7",   0, 5'd0,  32'h0,         0, 5'd0,  5'd7,  5'd5,  32'hA5A5A5A5,  32'h12345678,  2'b00, 6'd0,  32'hA5A5A5A5,  2'b00);
        cyc("iss_wr9",     1, 5'd9,  32'h55,        1, 5'd9,  5'd9,  5'd7,  32'h55,        32'hA5A5A5A5,  2'b00, 6'd0,  32'h0,         2'b00);
        cyc("chk9",        0, 5'd0,  32'h0,         0, 5'd0,  5'd9,  5'd9,  32'h55,        32'h55,        2'b11, 6'd1,  32'h55,        2'b11);
        cyc("set10_clr9",  1, 5'd9,  32'h66,        1, 5'd10, 5'd10, 5'd9,  32'h0,         32'h66,        2'b00, 6'd1,  32'h0,         2'b10);
        cyc("chk10",       0, 5'd0,  32'h0,         0, 5'd0,  5'd10, 5'd9,  32'h0,         32'h66,        2'b01, 6'd1,  32'h0,         2'b01);
        cyc("wr10",        1, 5'd10, 32'h10,        0, 5'd0,  5'd1,  5'd2,  32'h0,         32'h0,         2'b00, 6'd1,  32'h0,         2'b00);

        // Fill the scoreboard one register per cycle; port 1 trails to see the previous issue land.
        for (int k = 1; k < 32; k++) begin
            logic [4:0] cur, prv;
            cur = 5'(k);
            prv = 5'(k - 1);
            cyc("fill", 0, 5'd0, 32'h0, 1, cur, cur, prv, regVal(cur), regVal(prv),
                {(k > 1), 1'b0}, 6'(k - 1), regVal(cur), {(k > 1), 1'b0});
        end

        cyc("cnt31",       0, 5'd0,  32'h0,         0, 5'd0,  5'd3,  5'd31, 32'h0,         32'h0,         2'b11, 6'd31, 32'h0,         2'b11);
        cyc("reiss3",      0, 5'd0,  32'h0,         1, 5'd3,  5'd3,  5'd0,  32'h0,         32'h0,         2'b01, 6'd31, 32'h0,         2'b01);
        cyc("iss0",        0, 5'd0,  32'h0,         1, 5'd0,  5'd0,  5'd3,  32'h0,         32'h0,         2'b10, 6'd31, 32'h0,         2'b10);
        cyc("chk31",       0, 5'd0,  32'h0,         0, 5'd0,  5'd1,  5'd5,  32'h0,         32'h12345678,  2'b11, 6'd31, 32'h0,         2'b11);

        // Asynchronous reset in the middle of a cycle carrying a write and an issue to x6.
        @(posedge clk);
        #1;
        drive(1'b1, 5'd6, 32'hFFFF_FFFF, 1'b1, 5'd6, 5'd5, 5'd7);
        push("mid_rst", 32'h0, 32'h0, 2'b00, 6'd0, 32'h0, 2'b00);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;

        cyc("post_rst",    0, 5'd0,  32'h0,         0, 5'd0,  5'd6,  5'd5,  32'h0,         32'h0,         2'b00, 6'd0,  32'h0,         2'b00);
        cyc("post_wr",     1, 5'd6,  32'hCAFEF00D,  0, 5'd0,  5'd6,  5'd6,  32'hCAFEF00D,  32'hCAFEF00D,  2'b00, 6'd0,  32'h0,         2'b00);
        cyc("post_rd",     0, 5'd0,  32'h0,         0, 5'd0,  5'd6,  5'd9,  32'hCAFEF00D,  32'h0,         2'b00, 6'd0,  32'hCAFEF00D,  2'b00);

        @(posedge clk);
        #1 drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        chk("drain", "queue_left", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
